// File: rtl/byte_mem_if.sv
// Handshake and address signals of the byte-wide memory bus.
// The bidirectional MD data lines are not part of this bundle; they sit on
// the responder as a top-level inout so the tristate resolves at the pins.
interface byte_mem_if;
   logic        MREQ;
   logic [31:0] MADDR;
   logic        MWE;
   logic        MRDY;
   logic        MERR;
   logic        BUSY;

   modport master (output MREQ, MADDR, MWE, input MRDY, MERR, BUSY);
   modport slave  (input MREQ, MADDR, MWE, output MRDY, MERR, BUSY);
endinterface

// File: rtl/byte_mem_responder.sv
// Memory-side responder: one byte per MREQ/MRDY handshake, backed by an
// internal byte-addressed RAM, with a fixed access latency of LATENCY edges.
module byte_mem_responder #(
   parameter int ADDR_BITS = 10,
   parameter int LATENCY   = 2
) (
   input  logic       CLK,
   input  logic       RST_N,
   byte_mem_if.slave  bus,
   inout  wire  [7:0] MD
);

   localparam int       DEPTH    = 1 << ADDR_BITS;
   localparam bit [3:0] CNT_LAST = 4'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK, S_HOLD} state_t;

   state_t                 state_q, state_d;
   logic                   fire;
   logic [3:0]             cnt_q;
   logic [31:0]            addr_q;
   logic                   we_q;
   logic                   mrdy_q;
   logic                   merr_q;
   logic                   rd_oe_q;
   logic [7:0]             rdata_q;
   logic                   in_range;
   logic                   ram_en;
   logic [ADDR_BITS-1:0]   ram_idx;
   logic [7:0]             mem [DEPTH];

   assign in_range = (addr_q[31:ADDR_BITS] == '0);
   assign ram_idx  = addr_q[ADDR_BITS-1:0];
   // A reset landing on the completion edge must not commit the write.
   assign ram_en   = fire & RST_N;

   // Next-state decode; fire marks the BUSY->ACK edge where the RAM is accessed.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      fire    = 1'b0;
      case (state_q)
         S_IDLE:  if (bus.MREQ) state_d = S_BUSY;
         S_BUSY:  if (cnt_q == CNT_LAST) begin
                     state_d = S_ACK;
                     fire    = 1'b1;
                  end
         S_ACK:   state_d = S_HOLD;
         S_HOLD:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register, latency counter and the registered handshake outputs.
   always_ff @(posedge CLK) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // sees the pre-edge values of the others, independent of statement order.
      if (!RST_N) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         mrdy_q  <= 1'b0;
         merr_q  <= 1'b0;
         rd_oe_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: if (bus.MREQ) cnt_q <= 4'd0;
            S_BUSY: begin
               if (fire) begin
                  mrdy_q  <= 1'b1;
                  merr_q  <= ~in_range;
                  rd_oe_q <= ~we_q;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            S_ACK: begin
               mrdy_q <= 1'b0;
               merr_q <= 1'b0;
            end
            S_HOLD:  rd_oe_q <= 1'b0;
            default: ;
         endcase
      end
   end

   // Request capture; the operation is frozen here for the whole access.
   always_ff @(posedge CLK) begin
      if (state_q == S_IDLE && bus.MREQ) begin
         addr_q <= bus.MADDR;
         we_q   <= bus.MWE;
      end
   end

   // Single-port RAM: write from MD or read into rdata on the completion edge.
   always_ff @(posedge CLK) begin
      // NOTE: the RAM and its read register carry no reset so the array maps
      // onto block RAM and keeps its contents across RST_N.
      if (ram_en && we_q && in_range) mem[ram_idx] <= MD;
      if (ram_en && !we_q) rdata_q <= in_range ? mem[ram_idx] : 8'h00;
   end

   assign MD       = (rd_oe_q && !bus.MWE) ? rdata_q : 8'bz;
   assign bus.MRDY = mrdy_q;
   assign bus.MERR = merr_q;
   assign bus.BUSY = (state_q != S_IDLE);

endmodule

// File: doc/byte_mem_responder.md
Name: byte_mem_responder

Overview:
- Memory-side responder for the byte-wide, MRDY-handshaked memory bus driven by the CPU's cache controller.
- Backs the bus with an internal byte-addressed RAM and has a programmable access latency.
- Serves one byte per handshake on the bidirectional MD channel. Multi-byte words are moved by the initiator as repeated single-byte accesses.

Parameters:
ADDR_BITS, 10, log2 of RAM depth in bytes (depth = 2**ADDR_BITS)
LATENCY, 2, clock edges from request capture to MRDY assertion; legal range 1..15

Ports:
CLK  input  1  clock, all logic on rising edge
RST_N  input  1  synchronous active-low reset
MREQ  input  1  access request, level; sampled only in IDLE
MADDR  input  32  byte address; captured with the request
MWE  input  1  1 = write, 0 = read; captured with the request; also gates the MD driver
MD  inout  8  data: initiator drives on writes, this block drives on reads
MRDY  output  1  single-cycle registered access-complete pulse
MERR  output  1  single-cycle pulse, coincident with MRDY, when the captured address is out of range
BUSY  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (RST_N=0 at an edge):
  - state=IDLE, MRDY=0, MERR=0, read-drive enable=0, counter=0.
  - RAM contents are not cleared.
  - Reset mid-access aborts the access with no RAM write and no MRDY.
- MD driver: MD = (rd_oe & ~MWE) ? rdata : 8'bZ. This block never drives MD while MWE=1, even if rd_oe is set.
- State machine, registered:
  - IDLE: if MREQ=1, capture addr_q<=MADDR, we_q<=MWE, cnt<=0, go BUSY. Otherwise stay.
  - BUSY: if cnt==LATENCY-1, go ACK. Otherwise cnt<=cnt+1.
  - On the BUSY->ACK edge:
    - MRDY<=1.
    - Read: rdata<=RAM[addr_q], rd_oe<=1.
    - Write: RAM[addr_q]<=MD, sampled at this edge.
    - Out of range: MERR<=1.
  - ACK: one cycle, MRDY visible. Next edge: MRDY<=0, MERR<=0, go HOLD.
  - HOLD: one cycle; rd_oe and rdata still held, so a read initiator can sample MD one cycle after seeing MRDY. Next edge: rd_oe<=0, go IDLE.
- Latency:
  - MREQ sampled at edge s; MRDY is high during the cycle after edge s+LATENCY.
  - Minimum request-to-request spacing is LATENCY+3 edges (IDLE, LATENCY BUSY edges, ACK, HOLD).
- Captured operation is fixed for the whole access. Changes on MADDR or MWE after capture have no effect, except MWE=1 disabling the MD driver.
- Write data must be stable on MD at the BUSY->ACK edge.
- MREQ is ignored outside IDLE.
- If MREQ is still high when the block returns to IDLE, a new access starts at that IDLE edge. Back-to-back accesses need no gap edge.
- Range: addr_q[31:ADDR_BITS] != 0 means out of range:
  - Write is dropped.
  - Read returns 8'h00.
  - MRDY still pulses, with MERR.
- RAM indexed by addr_q[ADDR_BITS-1:0]. Single-port, inferable as BRAM. Optional $readmemh init is controlled by a define, not a parameter.
- Compatibility with the cache controller's single-byte loops:
  - MRDY is a one-cycle pulse.
  - The initiator increments MADDR on the MRDY edge.
  - The next access is captured fresh at the following IDLE.
  - No address-change detection is done.

Test Plan:
- Reset, then MREQ=1, MWE=1, MADDR=0x10, MD=0xA5, LATENCY=2 -> MRDY high exactly 1 cycle, 2 edges after capture; a later read of 0x10 -> MD=0xA5 during ACK and HOLD, Z otherwise.
- 4-byte word write 0x11223344 to 0x20..0x23 via four handshakes (LSB first), then four reads -> bytes 0x44, 0x33, 0x22, 0x11. Each MRDY is a single-cycle pulse; accesses are spaced exactly 5 edges with MREQ held high.
- Read 0x0000_0400 with ADDR_BITS=10 -> MRDY and MERR both pulse, MD=0x00. Write 0x400 with 0xFF -> MERR pulses, and RAM[0x000] is unchanged on readback.
- Start a write to 0x30 with MD=0x77, assert RST_N=0 during BUSY -> no MRDY, BUSY=0 next cycle, RAM[0x30] keeps its old value; prior contents elsewhere are preserved.
- Capture a read at 0x40, then change MADDR to 0x41 and toggle MREQ during BUSY -> data is from 0x40 and there is exactly one MRDY. Force MWE=1 during HOLD -> MD goes Z that cycle (no contention).
- LATENCY=1 and LATENCY=15 builds -> MRDY appears 1 and 15 edges after capture respectively.
